// File: rtl/i2s_reader_phy_multi.sv
// i2s_reader_phy_multi: I2S / left-justified capture PHY in the bit-clock domain.
// Deserialises LR/data into SAMPLE_WIDTH-bit samples, frames them into 32-bit words
// and streams them into a ping-pong pair of write FIFOs.
// Optional dropped-word counter: define I2S_READER_OVERFLOW_CNT_EN.
module i2s_reader_phy_multi #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned COUNT_WIDTH  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_mode,
    input  logic [1:0]             i_channel_mask,
    input  logic                   i_sign_extend,
    input  logic [COUNT_WIDTH-1:0] i_wfifo_size,
    input  logic [1:0]             i_wfifo_ready,
    output logic [1:0]             o_wfifo_activate,
    output logic                   o_wfifo_strobe,
    output logic [31:0]            o_wfifo_data,
    output logic                   o_synced,
    output logic [15:0]            o_overflow_count,
    input  logic                   i_i2s_lr,
    input  logic                   i_i2s_data,
    output logic [31:0]            debug
);

    localparam logic [5:0] SwIdx = 6'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StStream = 2'd2
    } state_e;

    logic                    lr_q, lr_dly_q, data_q;
    logic                    lr_edge;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [5:0]              bit_idx;
    logic                    bit_take;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [30:0]             sample_ext;
    logic                    synced_q, synced_d;
    logic                    word_vld_q, word_vld_d;
    logic [31:0]             word_q, word_d;
    state_e                  state_q, state_d;
    logic [1:0]              activate_q, activate_d;
    logic                    strobe_q, strobe_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [31:0]             debug_q, debug_d;

    assign lr_edge = lr_q != lr_dly_q;

    // Bit position within the slot and MSB-first placement into the sample register.
    always_comb begin
        bit_cnt_d = lr_edge ? 5'd0 : ((bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1);
        // LJ: MSB sits in the edge cycle; I2S: one bit later, and the edge-cycle bit is ignored.
        if (i_mode) begin
            bit_idx = lr_edge ? 6'd0 : {1'b0, bit_cnt_q} + 6'd1;
        end else begin
            bit_idx = {1'b0, bit_cnt_q};
        end
        bit_take = (i_mode || !lr_edge) && (bit_idx < SwIdx);
        // A new slot starts from zero so a short slot leaves its missing LSBs at 0.
        shift_d = lr_edge ? '0 : shift_q;
        for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
            if (bit_take && (6'(i) == SwIdx - 6'd1 - bit_idx)) begin
                shift_d[i] = data_q;
            end
        end
    end

    // Frame the completed slot on each LR edge and track frame lock.
    always_comb begin
        sample_ext = 31'(shift_q);
        word_d     = word_q;
        word_vld_d = 1'b0;
        if (lr_edge) begin
            word_d[31] = lr_dly_q;
            for (int i = 0; i < 31; i++) begin
                word_d[i] = (i < int'(SAMPLE_WIDTH)) ? sample_ext[i]
                                                     : (i_sign_extend & shift_q[SAMPLE_WIDTH-1]);
            end
            // synced_q is still 0 on the locking edge, so the partial slot is discarded.
            word_vld_d = synced_q && i_channel_mask[lr_dly_q];
        end
        if (state_q == StIdle || !i_enable) begin
            synced_d = 1'b0;
        end else begin
            synced_d = synced_q | lr_edge;
        end
    end

    // Pin capture, slot deserialiser and word pipeline stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lr_q       <= 1'b0;
            lr_dly_q   <= 1'b0;
            data_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            shift_q    <= '0;
            synced_q   <= 1'b0;
            word_vld_q <= 1'b0;
            word_q     <= 32'd0;
        end else begin
            lr_q       <= i_i2s_lr;
            lr_dly_q   <= lr_q;
            data_q     <= i_i2s_data;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            synced_q   <= synced_d;
            word_vld_q <= word_vld_d;
            word_q     <= word_d;
        end
    end

    // FIFO ownership FSM: claim a free buffer, write size words, release.
    always_comb begin
        state_d    = state_q;
        activate_d = activate_q;
        strobe_d   = 1'b0;
        wdata_d    = wdata_q;
        count_d    = count_q;
        unique case (state_q)
            StIdle: begin
                activate_d = 2'b00;
                if (i_enable) state_d = StWait;
            end
            StWait: begin
                activate_d = 2'b00;
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (i_wfifo_ready != 2'b00) begin
                    activate_d = i_wfifo_ready[0] ? 2'b01 : 2'b10;
                    count_d    = '0;
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (!i_enable) begin
                    activate_d = 2'b00;
                    state_d    = StIdle;
                end else if (count_q == i_wfifo_size) begin
                    activate_d = 2'b00;
                    state_d    = StWait;
                end else if (word_vld_q) begin
                    strobe_d = 1'b1;
                    wdata_d  = word_q;
                    count_d  = count_q + COUNT_WIDTH'(1);
                end
            end
            default: begin
                activate_d = 2'b00;
                state_d    = StIdle;
            end
        endcase
    end

    // FSM state and registered FIFO-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            activate_q <= 2'b00;
            strobe_q   <= 1'b0;
            wdata_q    <= 32'd0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            activate_q <= activate_d;
            strobe_q   <= strobe_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
        end
    end

`ifdef I2S_READER_OVERFLOW_CNT_EN
    logic        drop;
    logic [15:0] ovf_q, ovf_d;

    // Any word that reaches the FSM stage without being written is a drop.
    assign drop = word_vld_q & ~strobe_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StIdle && i_enable) begin
            ovf_d = 16'd0;
        end else if (drop && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Saturating dropped-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 16'd0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow_count = ovf_q;
`else
    assign o_overflow_count = 16'd0;
`endif

    assign debug_d = {21'd0, synced_q, state_q, strobe_q, activate_q,
                      i_wfifo_ready, i_enable, data_q, lr_q};

    // Debug snapshot, registered so it reads 0 throughout reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debug_q <= 32'd0;
        end else begin
            debug_q <= debug_d;
        end
    end

    assign o_wfifo_activate = activate_q;
    assign o_wfifo_strobe   = strobe_q;
    assign o_wfifo_data     = wdata_q;
    assign o_synced         = synced_q;
    assign debug            = debug_q;

endmodule

// File: tb/tb_i2s_reader_phy_multi.sv
// Directed bench for i2s_reader_phy_multi: a 24-bit and a 16-bit instance share the pins.
module tb_i2s_reader_phy_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_mode = 1'b0;
    logic [1:0]  i_channel_mask = 2'b00;
    logic        i_sign_extend = 1'b0;
    logic [23:0] i_wfifo_size = 24'd0;
    logic [1:0]  i_wfifo_ready = 2'b00;
    logic        i_i2s_lr = 1'b1;
    logic        i_i2s_data = 1'b0;

    logic [1:0]  a_act, b_act;
    logic        a_stb, b_stb;
    logic [31:0] a_data, b_data;
    logic        a_sync, b_sync;
    logic [15:0] a_ovf, b_ovf;
    logic [31:0] a_dbg, b_dbg;

    always #5 clk = ~clk;

    i2s_reader_phy_multi #(.SAMPLE_WIDTH(24), .COUNT_WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode),
        .i_channel_mask(i_channel_mask), .i_sign_extend(i_sign_extend),
        .i_wfifo_size(i_wfifo_size), .i_wfifo_ready(i_wfifo_ready),
        .o_wfifo_activate(a_act), .o_wfifo_strobe(a_stb), .o_wfifo_data(a_data),
        .o_synced(a_sync), .o_overflow_count(a_ovf), .i_i2s_lr(i_i2s_lr),
        .i_i2s_data(i_i2s_data), .debug(a_dbg)
    );

    i2s_reader_phy_multi #(.SAMPLE_WIDTH(16), .COUNT_WIDTH(24)) u_dut16 (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode),
        .i_channel_mask(i_channel_mask), .i_sign_extend(i_sign_extend),
        .i_wfifo_size(i_wfifo_size), .i_wfifo_ready(i_wfifo_ready),
        .o_wfifo_activate(b_act), .o_wfifo_strobe(b_stb), .o_wfifo_data(b_data),
        .o_synced(b_sync), .o_overflow_count(b_ovf), .i_i2s_lr(i_i2s_lr),
        .i_i2s_data(i_i2s_data), .debug(b_dbg)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int edge_c = 0;
    int base_a = 0, base_b = 0, base_h = 0;

    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [31:0] qb_data[$];
    logic [1:0]  act_hist[$];
    int          act_cyc[$];
    logic [1:0]  act_prev = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobed words and activate transitions, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_stb === 1'b1) begin
            qa_data.push_back(a_data);
            qa_cyc.push_back(cyc);
        end
        if (b_stb === 1'b1) qb_data.push_back(b_data);
        if (a_act !== act_prev) begin
            act_hist.push_back(a_act);
            act_cyc.push_back(cyc);
        end
        act_prev = a_act;
    end

    typedef struct {
        logic        mode;
        logic        sext;
        logic [1:0]  mask;
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] got_a(input int k);
        if (base_a + k < qa_data.size()) return qa_data[base_a + k];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] got_b(input int k);
        if (base_b + k < qb_data.size()) return qb_data[base_b + k];
        return 32'hxxxxxxxx;
    endfunction

    function automatic int cyc_a(input int k);
        if (base_a + k < qa_cyc.size()) return qa_cyc[base_a + k];
        return -1;
    endfunction

    function automatic logic [1:0] hist(input int k);
        if (base_h + k < act_hist.size()) return act_hist[base_h + k];
        return 2'bxx;
    endfunction

    function automatic int hist_cyc(input int k);
        if (base_h + k < act_cyc.size()) return act_cyc[base_h + k];
        return -1;
    endfunction

    // Serialise nbits of a slot; s holds the sample right-aligned in its sw bits.
    task automatic send_slot(input logic ch, input logic [31:0] s, input int sw, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int pos;
            pos = i_mode ? k : k - 1;
            @(negedge clk);
            if (k == 0) edge_c = cyc;
            i_i2s_lr   = ch;
            i_i2s_data = (pos >= 0 && pos < sw) ? s[sw-1-pos] : 1'b0;
        end
    endtask

    // Reset, configure, enable, and idle LR high so the next low slot is the lock edge.
    task automatic start(input logic mode, input logic sext, input logic [1:0] mask,
                         input logic [23:0] size, input logic [1:0] ready);
        @(negedge clk);
        rst = 1'b0;
        i_enable = 1'b0;
        i_i2s_lr = 1'b1;
        i_i2s_data = 1'b0;
        i_mode = mode;
        i_sign_extend = sext;
        i_channel_mask = mask;
        i_wfifo_size = size;
        i_wfifo_ready = ready;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        base_a = qa_data.size();
        base_b = qb_data.size();
        base_h = act_hist.size();
        i_enable = 1'b1;
        send_slot(1'b1, 32'd0, 24, 8);
    endtask

    int e_r;
    int n0;
    logic [31:0] exp_ovf;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'b11, 24'hABCDEF, 24'h123456, 32'h00ABCDEF, 32'h80123456};
        vecs[1] = '{1'b0, 1'b1, 2'b11, 24'h800001, 24'h7FFFFF, 32'h7F800001, 32'h807FFFFF};
        vecs[2] = '{1'b1, 1'b1, 2'b11, 24'hABCDEF, 24'h123456, 32'h7FABCDEF, 32'h80123456};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 24'hFFFFFF, 24'h000001, 32'h00FFFFFF, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 24'h0F0F0F, 24'hF0F0F0, 32'h0, 32'hFFF0F0F0};

        // Reset values while rst is held low.
        #12;
        chk("rst_act", 32'(a_act), 32'd0);
        chk("rst_stb", 32'(a_stb), 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_sync", 32'(a_sync), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_dbg", a_dbg, 32'd0);

        // I2S stereo, size 4: data, latency, release and re-activation.
        start(1'b0, 1'b0, 2'b11, 24'd4, 2'b01);
        send_slot(1'b0, 32'hABCDEF, 24, 32);
        send_slot(1'b1, 32'h123456, 24, 32);
        e_r = edge_c;
        send_slot(1'b0, 32'hABCDEF, 24, 32);
        send_slot(1'b1, 32'h123456, 24, 32);
        chk("t1_dbg_state", 32'(a_dbg[10:8]), 32'd6);
        chk("t1_dbg_act", 32'(a_dbg[6:5]), 32'd1);
        chk("t1_dbg_hi", 32'(a_dbg[31:11]), 32'd0);
        send_slot(1'b0, 32'd0, 24, 32);
        chk("t1_count", 32'(qa_data.size() - base_a), 32'd4);
        chk("t1_w0", got_a(0), 32'h00ABCDEF);
        chk("t1_w1", got_a(1), 32'h80123456);
        chk("t1_w2", got_a(2), 32'h00ABCDEF);
        chk("t1_w3", got_a(3), 32'h80123456);
        chk("t1_latency", 32'(cyc_a(0)), 32'(e_r + 3));
        chk("t1_act0", 32'(hist(0)), 32'd1);
        chk("t1_rel", 32'(hist(1)), 32'd0);
        chk("t1_rel_cyc", 32'(hist_cyc(1)), 32'(cyc_a(3) + 1));
        chk("t1_react", 32'(hist(2)), 32'd1);
        chk("t1_react_cyc", 32'(hist_cyc(2)), 32'(cyc_a(3) + 2));

        // Table: one frame per vector on the 24-bit instance.
        for (int v = 0; v < 5; v++) begin
            int k;
            start(vecs[v].mode, vecs[v].sext, vecs[v].mask, 24'd64, 2'b01);
            send_slot(1'b0, 32'(vecs[v].l), 24, 32);
            send_slot(1'b1, 32'(vecs[v].r), 24, 32);
            send_slot(1'b0, 32'd0, 24, 32);
            chk($sformatf("vec%0d_count", v), 32'(qa_data.size() - base_a),
                32'(vecs[v].mask[0]) + 32'(vecs[v].mask[1]));
            k = 0;
            if (vecs[v].mask[0]) begin
                chk($sformatf("vec%0d_left", v), got_a(k), vecs[v].exp_l);
                k++;
            end
            if (vecs[v].mask[1]) chk($sformatf("vec%0d_right", v), got_a(k), vecs[v].exp_r);
        end

        // LJ, 16-bit sample, sign-extend on then off.
        start(1'b1, 1'b1, 2'b01, 24'd64, 2'b01);
        send_slot(1'b0, 32'h8001, 16, 32);
        send_slot(1'b1, 32'h0, 16, 32);
        chk("lj16_sext_count", 32'(qb_data.size() - base_b), 32'd1);
        chk("lj16_sext", got_b(0), 32'h7FFF8001);
        start(1'b1, 1'b0, 2'b01, 24'd64, 2'b01);
        send_slot(1'b0, 32'h8001, 16, 32);
        send_slot(1'b1, 32'h0, 16, 32);
        chk("lj16_zero", got_b(0), 32'h00008001);

        // Right-only mask over 8 frames.
        start(1'b0, 1'b0, 2'b10, 24'd64, 2'b01);
        for (int f = 0; f < 8; f++) begin
            send_slot(1'b0, 32'h555555, 24, 32);
            send_slot(1'b1, 32'h0A0000 + 32'(f), 24, 32);
        end
        send_slot(1'b0, 32'd0, 24, 32);
        chk("mask_count", 32'(qa_data.size() - base_a), 32'd8);
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("mask_w%0d", f), got_a(f), 32'h800A0000 + 32'(f));
        end

        // Ping-pong: size 2, ready 11 -> 10 -> 00, extra words dropped.
        start(1'b0, 1'b0, 2'b11, 24'd2, 2'b11);
        i_wfifo_ready = 2'b10;
        send_slot(1'b0, 32'h111111, 24, 32);
        send_slot(1'b1, 32'h222222, 24, 32);
        send_slot(1'b0, 32'h333333, 24, 32);
        i_wfifo_ready = 2'b00;
        send_slot(1'b1, 32'h444444, 24, 32);
        for (int f = 0; f < 2; f++) begin
            send_slot(1'b0, 32'h666666, 24, 32);
            send_slot(1'b1, 32'h777777, 24, 32);
        end
        send_slot(1'b0, 32'd0, 24, 32);
        chk("pp_count", 32'(qa_data.size() - base_a), 32'd4);
        chk("pp_w0", got_a(0), 32'h00111111);
        chk("pp_w1", got_a(1), 32'h80222222);
        chk("pp_w2", got_a(2), 32'h00333333);
        chk("pp_w3", got_a(3), 32'h80444444);
        chk("pp_hist0", 32'(hist(0)), 32'd1);
        chk("pp_hist1", 32'(hist(1)), 32'd0);
        chk("pp_hist2", 32'(hist(2)), 32'd2);
        chk("pp_hist3", 32'(hist(3)), 32'd0);
        chk("pp_hist_len", 32'(act_hist.size() - base_h), 32'd4);
`ifdef I2S_READER_OVERFLOW_CNT_EN
        exp_ovf = 32'd4;
`else
        exp_ovf = 32'd0;
`endif
        chk("pp_ovf", 32'(a_ovf), exp_ovf);

        // Zero-size buffer: claims and releases without writing.
        start(1'b0, 1'b0, 2'b11, 24'd0, 2'b01);
        send_slot(1'b0, 32'h123123, 24, 32);
        send_slot(1'b1, 32'h321321, 24, 32);
        send_slot(1'b0, 32'd0, 24, 32);
        chk("zero_count", 32'(qa_data.size() - base_a), 32'd0);
        chk("zero_toggles", 32'(act_hist.size() - base_h >= 3), 32'd1);

        // Disable mid-slot.
        start(1'b0, 1'b0, 2'b11, 24'd64, 2'b01);
        send_slot(1'b0, 32'hABCDEF, 24, 32);
        send_slot(1'b1, 32'h123456, 24, 32);
        send_slot(1'b0, 32'hABCDEF, 24, 10);
        @(negedge clk);
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_act", 32'(a_act), 32'd0);
        chk("dis_sync", 32'(a_sync), 32'd0);
        n0 = qa_data.size() - base_a;
        chk("dis_before", 32'(n0), 32'd2);
        send_slot(1'b0, 32'hABCDEF, 24, 20);
        send_slot(1'b1, 32'h123456, 24, 32);
        send_slot(1'b0, 32'd0, 24, 32);
        chk("dis_after", 32'(qa_data.size() - base_a), 32'(n0));
        chk("dis_state", 32'(a_dbg[9:8]), 32'd0);

        // Asynchronous reset mid-word.
        start(1'b0, 1'b0, 2'b11, 24'd64, 2'b01);
        send_slot(1'b0, 32'hABCDEF, 24, 32);
        send_slot(1'b1, 32'h123456, 24, 32);
        send_slot(1'b0, 32'hABCDEF, 24, 10);
        chk("prerst_data", a_data, 32'h80123456);
        chk("prerst_act", 32'(a_act), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_act", 32'(a_act), 32'd0);
        chk("arst_stb", 32'(a_stb), 32'd0);
        chk("arst_data", a_data, 32'd0);
        chk("arst_sync", 32'(a_sync), 32'd0);
        chk("arst_ovf", 32'(a_ovf), 32'd0);
        chk("arst_dbg", a_dbg, 32'd0);
        n0 = qa_data.size();
        send_slot(1'b1, 32'h123456, 24, 32);
        send_slot(1'b0, 32'h123456, 24, 8);
        chk("arst_no_stb", 32'(qa_data.size()), 32'(n0));
        chk("arst_state", 32'(a_dbg[9:8]), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
